// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the proc fetch and data ports.
// IDLE/BUSY/RESP handshake FSM with round-robin or data priority and a hung-access watchdog.
module mem_port_arbiter #(
    parameter bit          DATA_PRIORITY = 1'b1,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic        clk,
    input  logic        res,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_valid,
    output logic [31:0] instr_read,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_write,
    input  logic        data_write_enable,
    input  logic [3:0]  data_be,
    output logic        data_valid,
    output logic [31:0] data_read,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {GNT_INSTR, GNT_DATA} grant_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
    } mem_cmd_t;

    state_t      state;
    grant_t      last_grant;
    grant_t      next_grant;
    mem_cmd_t    next_cmd;
    logic [31:0] wd_cnt;
    logic        wd_expired;

    // last_grant doubles as the owner of the access while BUSY
    always_comb begin
        next_grant = GNT_INSTR;
        if (instr_req && data_req)
            next_grant = (DATA_PRIORITY || last_grant == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
        else if (data_req)
            next_grant = GNT_DATA;

        next_cmd = '{addr: instr_addr, wdata: 32'h0, we: 1'b0, be: 4'hF};
        if (next_grant == GNT_DATA)
            next_cmd = '{addr: data_addr, wdata: data_write, we: data_write_enable, be: data_be};
    end

    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == TIMEOUT - 1);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state       <= IDLE;
            last_grant  <= GNT_DATA;
            wd_cnt      <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            instr_valid <= 1'b0;
            instr_read  <= '0;
            data_valid  <= 1'b0;
            data_read   <= '0;
            bus_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_req || data_req) begin
                        mem_req    <= 1'b1;
                        mem_addr   <= next_cmd.addr;
                        mem_wdata  <= next_cmd.wdata;
                        mem_we     <= next_cmd.we;
                        mem_be     <= next_cmd.be;
                        last_grant <= next_grant;
                        wd_cnt     <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // a real completion wins over a watchdog expiry on the same edge
                    if (mem_valid || wd_expired) begin
                        mem_req <= 1'b0;
                        bus_err <= !mem_valid;
                        if (last_grant == GNT_DATA) begin
                            data_valid <= 1'b1;
                            data_read  <= mem_valid ? mem_rdata : 32'h0;
                        end else begin
                            instr_valid <= 1'b1;
                            instr_read  <= mem_valid ? mem_rdata : 32'h0;
                        end
                        wd_cnt <= '0;
                        state  <= RESP;
                    end else if (TIMEOUT != 0) begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                RESP: begin
                    instr_valid <= 1'b0;
                    data_valid  <= 1'b0;
                    bus_err     <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin/timeout instance (a) and
// data-priority instance (b) share the proc-side stimulus.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        res;
    logic        instr_req, data_req, data_write_enable;
    logic [31:0] instr_addr, data_addr, data_write;
    logic [3:0]  data_be;

    logic        instr_valid, data_valid, mem_req, mem_we, bus_err;
    logic [31:0] instr_read, data_read, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        ma_valid = 1'b0;
    logic [31:0] ma_rdata = 32'h0;

    logic        instr_valid_b, data_valid_b, mem_req_b, mem_we_b, bus_err_b;
    logic [31:0] instr_read_b, data_read_b, mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_be_b;
    logic        mb_valid = 1'b0;
    logic [31:0] mb_rdata = 32'h0;

    int          ma_wait;
    bit          ma_hang;
    logic [31:0] ma_data;
    bit          stale_tgl;
    bit          stale_seen = 1'b0;
    int          ma_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_PRIORITY(1'b0), .TIMEOUT(8)) dut_a (
        .clk(clk), .res(res),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_read(instr_read),
        .data_req(data_req), .data_addr(data_addr), .data_write(data_write),
        .data_write_enable(data_write_enable), .data_be(data_be),
        .data_valid(data_valid), .data_read(data_read),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_be(mem_be),
        .mem_valid(ma_valid), .mem_rdata(ma_rdata), .bus_err(bus_err)
    );

    mem_port_arbiter #(.DATA_PRIORITY(1'b1), .TIMEOUT(8)) dut_b (
        .clk(clk), .res(res),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid_b), .instr_read(instr_read_b),
        .data_req(data_req), .data_addr(data_addr), .data_write(data_write),
        .data_write_enable(data_write_enable), .data_be(data_be),
        .data_valid(data_valid_b), .data_read(data_read_b),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_we(mem_we_b), .mem_be(mem_be_b),
        .mem_valid(mb_valid), .mem_rdata(mb_rdata), .bus_err(bus_err_b)
    );

    // memory a: ma_wait stall cycles then a one-cycle completion; stale_tgl injects a spurious one
    always @(negedge clk) begin
        if (ma_valid) begin
            ma_valid = 1'b0;
            ma_cnt   = 0;
        end else if (stale_tgl != stale_seen) begin
            stale_seen = stale_tgl;
            ma_valid   = 1'b1;
            ma_rdata   = 32'hBAD0BAD0;
        end else if (mem_req && !ma_hang) begin
            if (ma_cnt == ma_wait) begin
                ma_valid = 1'b1;
                ma_rdata = ma_data;
            end else begin
                ma_cnt++;
            end
        end else begin
            ma_cnt = 0;
        end
    end

    // memory b: always zero-wait
    always @(negedge clk) begin
        mb_valid = mem_req_b && !mb_valid;
        mb_rdata = mem_addr_b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input string tag);
        int n = 0;
        ma_wait = 0; ma_data = d; instr_addr = a; instr_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 12);
        chk({tag, "_vld"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_rd"}, instr_read, d);
        instr_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout: simulation bound reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] pat;
        int nv, cyc, last, bi, bd, n, busy;

        res = 1'b0; instr_req = 1'b0; data_req = 1'b0; data_write_enable = 1'b0;
        instr_addr = '0; data_addr = '0; data_write = '0; data_be = '0;
        ma_wait = 0; ma_hang = 1'b0; ma_data = '0; stale_tgl = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_vld", {30'b0, instr_valid, data_valid}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        res = 1'b1;
        @(negedge clk);

        // fetch, zero-wait
        ma_data = 32'h00500093; instr_addr = 32'h10; instr_req = 1'b1;
        @(negedge clk);
        chk("f_mem_req", {31'b0, mem_req}, 32'd1);
        chk("f_mem_addr", mem_addr, 32'h10);
        chk("f_mem_be", {28'b0, mem_be}, 32'hF);
        chk("f_mem_we", {31'b0, mem_we}, 32'd0);
        chk("f_ivld_early", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("f_ivld", {31'b0, instr_valid}, 32'd1);
        chk("f_iread", instr_read, 32'h00500093);
        chk("f_dvld", {31'b0, data_valid}, 32'd0);
        chk("f_req_drop", {31'b0, mem_req}, 32'd0);
        instr_req = 1'b0;
        @(negedge clk);
        chk("f_ivld_pulse", {31'b0, instr_valid}, 32'd0);
        chk("f_iread_hold", instr_read, 32'h00500093);

        // store
        ma_data = 32'h11112222; data_addr = 32'h100; data_write = 32'hDEADBEEF;
        data_be = 4'b0011; data_write_enable = 1'b1; data_req = 1'b1;
        @(negedge clk);
        chk("s_mem_we", {31'b0, mem_we}, 32'd1);
        chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("s_mem_be", {28'b0, mem_be}, 32'h3);
        chk("s_mem_addr", mem_addr, 32'h100);
        @(negedge clk);
        chk("s_dvld", {31'b0, data_valid}, 32'd1);
        chk("s_ivld", {31'b0, instr_valid}, 32'd0);
        chk("s_dread", data_read, 32'h11112222);
        data_req = 1'b0; data_write_enable = 1'b0;
        @(negedge clk);
        chk("s_dvld_pulse", {31'b0, data_valid}, 32'd0);

        // contention: a alternates starting with instr, b always picks data
        instr_addr = 32'h200; data_addr = 32'h300; data_be = 4'hF; ma_data = 32'h0;
        instr_req = 1'b1; data_req = 1'b1;
        pat = '0; nv = 0; cyc = 0; last = 0; bi = 0; bd = 0; busy = 0;
        while (nv < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (instr_valid_b) bi++;
            if (data_valid_b) bd++;
            if (instr_valid && data_valid) busy++;
            if (instr_valid || data_valid) begin
                pat = {pat[2:0], data_valid};
                if (nv > 0) chk("rr_gap", cyc - last, 32'd3);
                last = cyc;
                nv++;
            end
        end
        data_req = 1'b0;
        chk("rr_count", nv, 32'd4);
        chk("rr_order", {28'b0, pat}, 32'b0101);
        chk("rr_both_vld", busy, 32'd0);
        chk("dp_instr", bi, 32'd0);
        chk("dp_data", bd, 32'd4);
        n = 0;
        while (!instr_valid_b && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("dp_instr_after_drop", {31'b0, instr_valid_b}, 32'd1);
        instr_req = 1'b0;
        repeat (2) @(negedge clk);

        // 5-cycle memory stall
        ma_wait = 5; ma_data = 32'hCAFEF00D; data_addr = 32'h400; data_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("st_mem_req", {31'b0, mem_req}, 32'd1);
            chk("st_mem_addr", mem_addr, 32'h400);
        end
        @(negedge clk);
        chk("st_dvld", {31'b0, data_valid}, 32'd1);
        chk("st_dread", data_read, 32'hCAFEF00D);
        chk("st_bus_err", {31'b0, bus_err}, 32'd0);
        data_req = 1'b0;
        @(negedge clk);
        chk("st_dvld_pulse", {31'b0, data_valid}, 32'd0);

        // watchdog timeout after 8 BUSY cycles
        ma_hang = 1'b1; data_addr = 32'h500; data_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("to_mem_req_hold", {31'b0, mem_req}, 32'd1);
        end
        @(negedge clk);
        chk("to_mem_req_drop", {31'b0, mem_req}, 32'd0);
        chk("to_dvld", {31'b0, data_valid}, 32'd1);
        chk("to_bus_err", {31'b0, bus_err}, 32'd1);
        chk("to_dread", data_read, 32'h0);
        data_req = 1'b0; ma_hang = 1'b0;
        @(negedge clk);
        chk("to_bus_err_pulse", {31'b0, bus_err}, 32'd0);
        do_fetch(32'h20, 32'h12345678, "to_next");

        // reset in the middle of BUSY, then a stale completion
        ma_wait = 10; instr_addr = 32'h30; instr_req = 1'b1;
        @(negedge clk);
        chk("rb_mem_req", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        res = 1'b0;
        #1;
        chk("rb_mem_req_clr", {31'b0, mem_req}, 32'd0);
        chk("rb_mem_addr_clr", mem_addr, 32'h0);
        chk("rb_iread_clr", instr_read, 32'h0);
        instr_req = 1'b0;
        @(negedge clk);
        res = 1'b1;
        stale_tgl = ~stale_tgl;
        busy = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (instr_valid || data_valid || mem_req) busy++;
        end
        chk("rb_stale_ignored", busy, 32'd0);
        do_fetch(32'h40, 32'h0badf00d, "rb_next");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
